// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, address field bounds, merge FSM states.
// Imported by merge21 and its arbiter.
package noc_pkg;

  localparam int FLIT_W  = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    DATA
  } merge_state_e;

endpackage

// File: rtl/merge21_arb2.sv
// arb2: combinational 2-way arbiter with a priority pointer.
// Ports: req0_i/req1_i requests, pri_i tie-break (0 = port 0), gnt_o one-hot.
module arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       pri_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = {req1_i, req0_i};
    if (req0_i && req1_i) begin
      gnt_o = pri_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/merge21.sv
// merge21: 2-to-1 NoC merge; emits a select token on S, then the flit.
// Ports: clk, reset (sync, high), in0/in1 valid/data/ready, s_*, out_*.
// Build option: MERGE_RR_EN enables round-robin, else In0 wins ties.
module merge21
  import noc_pkg::*;
#(
  parameter int W = FLIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  output logic         in1_ready,
  output logic         s_valid,
  output logic         s_data,
  input  logic         s_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  merge_state_e state_q;
  logic         pri_q;
  logic         win_q;
  logic [W-1:0] data_q;
  logic         s_valid_q;
  logic         out_valid_q;
  logic [1:0]   gnt;
  logic         idle;

  arb2 u_arb (
    .req0_i (in0_valid),
    .req1_i (in1_valid),
    .pri_i  (pri_q),
    .gnt_o  (gnt)
  );

  // Reset masks ready so no producer sees an accept that is dropped.
  assign idle      = (state_q == IDLE) && !reset;
  assign in0_ready = idle && gnt[0];
  assign in1_ready = idle && gnt[1];

  assign s_valid   = s_valid_q;
  assign s_data    = win_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      win_q       <= 1'b0;
      data_q      <= '0;
      s_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt[0] || gnt[1]) begin
            data_q    <= gnt[1] ? in1_data : in0_data;
            win_q     <= gnt[1];
            s_valid_q <= 1'b1;
            state_q   <= SEL;
          end
        end
        SEL: begin
          if (s_ready) begin
            s_valid_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
`ifdef MERGE_RR_EN
            pri_q       <= ~win_q;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge21.sv
// tb_merge21: directed and random checks of merge21 against a
// queue-based model of the merge (arbitration, token order, data).
module tb_merge21;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in0_valid = 1'b0;
  logic [8:0] in0_data = '0;
  logic       in0_ready;
  logic       in1_valid = 1'b0;
  logic [8:0] in1_data = '0;
  logic       in1_ready;
  logic       s_valid;
  logic       s_data;
  logic       s_ready = 1'b0;
  logic       out_valid;
  logic [8:0] out_data;
  logic       out_ready = 1'b0;

  merge21 dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

`ifdef MERGE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic       p;
    logic [8:0] d;
  } ent_t;

  ent_t       sb[$];
  logic       slog[$];
  logic [8:0] olog[$];

  int   nchk = 0;
  int   nerr = 0;
  int   nin  = 0;
  int   nout = 0;
  logic mpri = 1'b0;
  logic sdone = 1'b0;
  logic was_rst = 1'b0;
  logic ps_hold = 1'b0;
  logic ps_data = 1'b0;
  logic po_hold = 1'b0;
  logic [8:0] po_data = '0;
  logic f0, f1, fs, fo;
  int   rate0 = 0;
  int   rate1 = 0;
  bit   rnd_rdy = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Winner under the merge rules: lone requester wins, ties go to pri.
  function automatic logic winner(logic v0, logic v1, logic p);
    if (v0 && v1) return p;
    return v1;
  endfunction

  task automatic monitor();
    f0 = 1'b0; f1 = 1'b0; fs = 1'b0; fo = 1'b0;
    if (reset) begin
      check("rst_rdy0", in0_ready, 0);
      check("rst_rdy1", in1_ready, 0);
      sb.delete();
      mpri = 1'b0;
      sdone = 1'b0;
      ps_hold = 1'b0;
      po_hold = 1'b0;
      was_rst = 1'b1;
      return;
    end
    if (was_rst) begin
      check("rst_sv", s_valid, 0);
      check("rst_ov", out_valid, 0);
      check("rst_sd", s_data, 0);
      check("rst_od", out_data, 0);
    end
    if (ps_hold) check("s_hold", {s_valid, s_data}, {1'b1, ps_data});
    if (po_hold) check("o_hold", {out_valid, out_data}, {1'b1, po_data});
    check("rdy0_nov", in0_ready & ~in0_valid, 0);
    check("rdy1_nov", in1_ready & ~in1_valid, 0);
    f0 = in0_valid & in0_ready;
    f1 = in1_valid & in1_ready;
    fs = s_valid & s_ready;
    fo = out_valid & out_ready;
    check("one_gnt", f0 & f1, 0);
    if (f0 || f1) begin
      check("in_flight", sb.size(), 0);
      check("win", f1, winner(in0_valid, in1_valid, mpri));
      sb.push_back('{p: f1, d: f1 ? in1_data : in0_data});
      sdone = 1'b0;
      nin++;
    end
    if (fs) begin
      check("s_spur", sb.size() != 0, 1);
      check("s_dup", sdone, 0);
      if (sb.size() != 0) check("s_tok", s_data, sb[0].p);
      sdone = 1'b1;
      slog.push_back(s_data);
    end
    if (fo) begin
      check("o_spur", sb.size() != 0, 1);
      check("o_after_s", sdone, 1);
      if (sb.size() != 0) begin
        check("o_data", out_data, sb[0].d);
        if (RR) mpri = ~sb[0].p;
        void'(sb.pop_front());
      end
      sdone = 1'b0;
      olog.push_back(out_data);
      nout++;
    end
    ps_hold = s_valid & ~s_ready;
    ps_data = s_data;
    po_hold = out_valid & ~out_ready;
    po_data = out_data;
    was_rst = 1'b0;
  endtask

  task automatic drive();
    if (f0) in0_valid = 1'b0;
    if (f1) in1_valid = 1'b0;
    if (!in0_valid && rate0 > 0 && $urandom_range(99) < rate0) begin
      in0_valid = 1'b1;
      in0_data  = 9'($urandom);
    end
    if (!in1_valid && rate1 > 0 && $urandom_range(99) < rate1) begin
      in1_valid = 1'b1;
      in1_data  = 9'($urandom);
    end
    if (rnd_rdy) begin
      s_ready   = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    slog.delete();
    olog.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state_sv", s_valid, 0);
    check("rst_state_ov", out_valid, 0);
    #1;
    check("rst_state_r0", in0_ready, 0);
    check("rst_state_r1", in1_ready, 0);

    // Single flit on In0 with open sinks
    s_ready = 1'b1;
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data = 9'h0A5;
    #1;
    check("t1_rdy", in0_ready, 1);
    step();
    check("t1_sv", s_valid, 1);
    check("t1_sd", s_data, 0);
    check("t1_ov0", out_valid, 0);
    #1;
    check("t1_rdy_lo", in0_ready, 0);
    step();
    check("t1_ov", out_valid, 1);
    check("t1_od", out_data, 9'h0A5);
    check("t1_sv0", s_valid, 0);
    step();
    check("t1_done", out_valid, 0);

    // Simultaneous requests, held until accepted
    do_reset();
    s_ready = 1'b1;
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data = 9'h101;
    in1_valid = 1'b1;
    in1_data = 9'h1FE;
    repeat (8) step();
    check("t2_n", olog.size(), 2);
    if (olog.size() == 2 && slog.size() == 2) begin
      check("t2_o0", olog[0], 9'h101);
      check("t2_s0", slog[0], 0);
      check("t2_o1", olog[1], 9'h1FE);
      check("t2_s1", slog[1], 1);
    end

    // Continuous contention
    do_reset();
    rate0 = 100;
    rate1 = 100;
    repeat (62) step();
    rate0 = 0;
    rate1 = 0;
    check("t3_n", slog.size() >= 19, 1);
    for (int i = 0; i < slog.size(); i++)
      check("t3_alt", slog[i], RR ? (i % 2) : 0);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (4) step();

    // Backpressure on S then on Out
    do_reset();
    s_ready = 1'b0;
    out_ready = 1'b1;
    in1_valid = 1'b1;
    in1_data = 9'h155;
    step();
    in0_valid = 1'b1;
    in0_data = 9'h0F0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_sv", s_valid, 1);
      check("t4_r0", in0_ready, 0);
    end
    s_ready = 1'b1;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_ov", out_valid, 1);
      check("t4_od", out_data, 9'h155);
      check("t4_r0b", in0_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("t4_ns", slog.size(), 1);
    check("t4_no", olog.size(), 1);
    repeat (4) step();

    // Reset while holding a flit in DATA
    do_reset();
    s_ready = 1'b1;
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_data = 9'h0C3;
    step();
    step();
    check("t5_hold", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_ov", out_valid, 0);
    check("t5_sv", s_valid, 0);
    slog.delete();
    olog.delete();
    out_ready = 1'b1;
    in1_valid = 1'b1;
    in1_data = 9'h033;
    repeat (4) step();
    check("t5_n", olog.size(), 1);
    if (olog.size() == 1 && slog.size() == 1) begin
      check("t5_s", slog[0], 1);
      check("t5_o", olog[0], 9'h033);
    end

    // Random traffic and backpressure
    do_reset();
    nin = 0;
    nout = 0;
    rate0 = 40;
    rate1 = 40;
    rnd_rdy = 1'b1;
    repeat (10000) step();
    rate0 = 0;
    rate1 = 0;
    rnd_rdy = 1'b0;
    s_ready = 1'b1;
    out_ready = 1'b1;
    repeat (12) step();
    check("rnd_drain", sb.size(), 0);
    check("rnd_count", nout, nin);
    check("rnd_busy", nin > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/merge21.md
Name: merge21

Overview:
- 2-to-1 merge node for the NoC tree; it is the upstream-direction counterpart of the 1-to-2 address decoder.
- Arbitrates between two 9-bit flit input channels and forwards the winning flit on one output channel.
- Before each flit it emits a 1-bit select token on channel S that identifies the winning port (0 = In0, 1 = In1), so downstream logic can mirror the routing decision.
- Clocked valid/ready implementation of the CSP merge; one flit in flight at a time.

Parameters:
- W, 9, flit width. Bits [8:5] are the address nibble and bits [4:0] the payload; the block forwards the flit unchanged.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in0_valid  in  1  In0 flit valid.
- in0_data  in  W  In0 flit.
- in0_ready  out  1  In0 accept.
- in1_valid  in  1  In1 flit valid.
- in1_data  in  W  In1 flit.
- in1_ready  out  1  In1 accept.
- s_valid  out  1  select token valid.
- s_data  out  1  winning port index.
- s_ready  in  1  select token accept.
- out_valid  out  1  merged flit valid.
- out_data  out  W  merged flit.
- out_ready  in  1  merged flit accept.

Behaviour:
- Handshakes: a transfer occurs on a clk edge where valid && ready. Once a producer raises valid, it holds valid and data stable until the transfer.
  - in*_ready is combinational from state and inputs only, never from out_ready or s_ready.
  - s_valid, out_valid, s_data and out_data are registered.
- FSM states: IDLE, SEL, DATA.
- IDLE:
  - in*_ready is asserted only for the granted port, and only when that port's valid is high.
  - Grant with one requester: that requester wins.
  - Grant with both requesting: the port selected by priority pointer `pri` wins (pri=0 selects In0).
  - On a transfer: capture the flit into data_q, set win_q to the port index, go to SEL.
  - With no requester, stay in IDLE.
- SEL:
  - s_valid=1, s_data=win_q, both in*_ready=0.
  - On s_ready, go to DATA.
- DATA:
  - out_valid=1, out_data=data_q.
  - On out_ready: set pri to the inverse of win_q (when MERGE_RR_EN is defined) and go to IDLE.
- Latency:
  - Input accepted at edge t gives s_valid high in cycle t+1.
  - With s_ready tied high, out_valid is high in cycle t+2 and IDLE is re-entered after edge t+2.
  - Peak throughput is 1 flit per 3 cycles.
- Order: the S token always precedes its flit. A new input is never accepted before the previous flit's out transfer.
- Backpressure: s_ready or out_ready held low stalls indefinitely with outputs stable. There is no loss or duplication.
- Reset: synchronous and dominant over any handshake in the same cycle. The state after reset is:
  - state=IDLE, pri=0, win_q=0, data_q=0;
  - s_valid=0, out_valid=0, in0_ready=0, in1_ready=0.
- Reset mid-operation: a flit held in SEL or DATA is discarded. Upstream re-presents no data; this is a system-level concern.

Optional Feature:
- Macro MERGE_RR_EN.
- Defined: round-robin. pri toggles to favour the loser after each completed out transfer, so neither port starves under continuous contention.
- Undefined: fixed priority. pri stays 0, In0 always wins ties, and In1 can starve.

Decomposition:
- Package noc_pkg holds:
  - FLIT_W=9;
  - the address field bounds ADDR_HI=8, ADDR_LO=5;
  - typedef flit_t (logic [FLIT_W-1:0]);
  - enum merge_state_e {IDLE, SEL, DATA}.
- One sub-module is natural: arb2, a combinational 2-way arbiter taking (req0, req1, pri) and returning a one-hot grant.
- The FSM and datapath live in merge21.

Test Plan:
- Single flit on In0: data 9'h0A5, s_ready and out_ready held 1 → in0_ready pulses 1 cycle; s_valid with s_data=0 the next cycle; out_data=9'h0A5 the cycle after.
- Both ports valid: In0=9'h101, In1=9'h1FE, held until accepted, with MERGE_RR_EN → order is 0x101/S=0, then 0x1FE/S=1. Without the macro, under continuous In0 traffic, In1 is never granted.
- Backpressure: s_ready=0 for 5 cycles, then out_ready=0 for 4 cycles → outputs stable throughout; both in*_ready=0; exactly one S and one Out transfer.
- Continuous contention over 20 flits with MERGE_RR_EN → S tokens alternate 0,1,0,1…; the data sequence matches a scoreboard.
- Reset asserted while in DATA with out_ready=0 → next cycle out_valid=0, s_valid=0, state IDLE; a subsequent In1 flit 9'h033 is forwarded with S=1.
- Random valid/ready stimulus over 10k cycles → every flit appears exactly once and in per-port order, each preceded by a correct S token. Protocol-stability assertions hold on all channels.
